// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory between the CPU (port 0) and DMA/IO (port 1).
// Grants are combinational from registered owner/round-robin/run-length state.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        word_we0,
    input  logic        word_we1,
    input  logic        byte_we0,
    input  logic        byte_we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        stall0,
    output logic        stall1,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_LOCK) + 1;
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_LOCK);

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_0    = 2'd1;
    localparam logic [1:0] OWN_1    = 2'd2;

    logic [1:0]    owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] run_q, run_d;
    logic          below_max;
    logic          g0, g1;

    assign below_max = (run_q < RUN_MAX);

    // A locked owner keeps the memory until it hits the run limit while the other port waits.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (owner_q == OWN_0 && req0 && (below_max || !req1)) begin
                g0 = 1'b1;
            end else if (owner_q == OWN_1 && req1 && (below_max || !req0)) begin
                g1 = 1'b1;
            end else if (req0 && req1) begin
                g0 = last_q;
                g1 = ~last_q;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    end

    // last_q equals the previous grant whenever run_q is nonzero; run_q==0 restarts at 1 anyway.
    always_comb begin
        owner_d = OWN_IDLE;
        last_d  = last_q;
        run_d   = '0;
        if (g0 || g1) begin
            last_d = g1;
            if (g1) begin
                owner_d = lock1 ? OWN_1 : OWN_IDLE;
            end else begin
                owner_d = lock0 ? OWN_0 : OWN_IDLE;
            end
            if (g1 == last_q) begin
                run_d = below_max ? run_q + CW'(1) : run_q;
            end else begin
                run_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_IDLE;
            last_q  <= 1'b1;
            run_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            run_q   <= run_d;
        end
    end

    assign gnt0        = g0;
    assign gnt1        = g1;
    assign stall0      = req0 & ~g0;
    assign stall1      = req1 & ~g1;
    assign mem_addr    = g1 ? addr1 : addr0;
    assign mem_wdata   = g1 ? wdata1 : wdata0;
    assign mem_word_we = (g0 & word_we0) | (g1 & word_we1);
    assign mem_byte_we = (g0 & byte_we0) | (g1 & byte_we1);
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked against a behavioural model.
module tb_dmem_arbiter;

    localparam int ML = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        word_we0, word_we1, byte_we0, byte_we1;
    logic        gnt0, gnt1, stall0, stall1;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_word_we, mem_byte_we;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_LOCK(ML)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .word_we0(word_we0), .word_we1(word_we1), .byte_we0(byte_we0), .byte_we1(byte_we1),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata)
    );

    // Environment data memory: combinational read, word/byte write at the clock edge.
    logic [31:0] dmem [256];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clock) begin
        if (mem_word_we) dmem[mem_addr[9:2]] <= mem_wdata;
        if (mem_byte_we) dmem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
    end

    // Reference model: owner -1/0/1, last granted port, run length, previous cycle's grant.
    int          m_owner, m_last, m_run, m_prev;
    logic [31:0] ref_mem [256];
    logic        got0, got1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (reset) return -1;
        if (m_owner == 0 && req0 && (m_run < ML || !req1)) return 0;
        if (m_owner == 1 && req1 && (m_run < ML || !req0)) return 1;
        if (req0 && req1) return (m_last == 0) ? 1 : 0;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // Check one cycle at mid-low clock, then advance the model across the edge.
    task automatic cycle();
        int          g;
        logic [31:0] ea, ed;
        logic        ew, eb, lk;
        #4;
        g  = exp_grant();
        ea = (g == 1) ? addr1 : addr0;
        ed = (g == 1) ? wdata1 : wdata0;
        ew = (g == 0) ? word_we0 : (g == 1) ? word_we1 : 1'b0;
        eb = (g == 0) ? byte_we0 : (g == 1) ? byte_we1 : 1'b0;
        got0 = gnt0;
        got1 = gnt1;
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("stall0", 32'(stall0), 32'(req0 && g != 0));
        chk("stall1", 32'(stall1), 32'(req1 && g != 1));
        chk("mem_word_we", 32'(mem_word_we), 32'(ew));
        chk("mem_byte_we", 32'(mem_byte_we), 32'(eb));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("rdata", rdata, ref_mem[ea[9:2]]);
        @(posedge clock);
        if (reset) begin
            m_owner = -1; m_last = 1; m_run = 0; m_prev = -1;
        end else if (g >= 0) begin
            lk = (g == 1) ? lock1 : lock0;
            m_run   = (g == m_prev) ? ((m_run + 1 > ML) ? ML : m_run + 1) : 1;
            m_prev  = g;
            m_last  = g;
            m_owner = lk ? g : -1;
            if (ew) ref_mem[ea[9:2]] = ed;
            if (eb) ref_mem[ea[9:2]][8*ea[1:0] +: 8] = ed[7:0];
        end else begin
            m_owner = -1; m_run = 0; m_prev = -1;
        end
        #1;
    endtask

    task automatic set_req(input logic r0, input logic l0, input logic r1, input logic l1);
        req0 = r0; lock0 = l0; req1 = r1; lock1 = l1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            dmem[i] = v;
            ref_mem[i] = v;
        end
        m_owner = -1; m_last = 1; m_run = 0; m_prev = -1;
        reset = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        addr0 = 32'h1001_0100; addr1 = 32'h1001_0200;
        wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        word_we0 = 1'b0; word_we1 = 1'b0; byte_we0 = 1'b0; byte_we1 = 1'b0;

        // Reset with both requesting, then port 0 wins the first tie.
        cycle();
        chk("rst_gnt", {30'd0, got1, got0}, 32'd0);
        reset = 1'b0;
        cycle();
        chk("first_after_rst", {30'd0, got1, got0}, 32'd1);

        // Plain round-robin alternation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            addr0 = $urandom; addr1 = $urandom;
            cycle();
            chk("rr_alt", {30'd0, got1, got0}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Locked port 1 held for MAX_LOCK cycles, then forced handover.
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        set_req(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < ML + 1; i++) begin
            cycle();
            chk("lock_hand", {30'd0, got1, got0}, (i < ML) ? 32'd2 : 32'd1);
        end

        // Uncontended lock holds indefinitely; late requester wins on saturation.
        do_reset();
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("lock_hold", {30'd0, got1, got0}, 32'd1);
        end
        set_req(1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("lock_sat", {30'd0, got1, got0}, 32'd2);

        // Granted byte write beside an ungranted word write, then read back.
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        word_we0 = 1'b1; addr0 = 32'h1001_0040; wdata0 = 32'hDEAD_BEEF;
        byte_we1 = 1'b1; addr1 = 32'h1001_0003; wdata1 = 32'h0000_00AB;
        #4;
        chk("wr_byte_we", 32'(mem_byte_we), 32'd1);
        chk("wr_word_we", 32'(mem_word_we), 32'd0);
        chk("wr_addr", mem_addr, 32'h1001_0003);
        chk("wr_wdata", mem_wdata, 32'h0000_00AB);
        #1 clock = clock;
        // Finish the cycle through the model (the #4 above is part of this cycle's low phase).
        @(negedge clock);
        #0;
        word_we0 = 1'b0; byte_we1 = 1'b0;
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        addr1 = 32'h1001_0000;
        // Model catches up with the write explicitly since cycle() was bypassed.
        ref_mem[0][31:24] = 8'hAB;
        m_owner = -1; m_last = 1; m_run = 1; m_prev = 1;
        cycle();
        chk("rd_byte", 32'(rdata[31:24]), 32'h0000_00AB);

        // Reset during a port-1 lock aborts ownership and restores last.
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        set_req(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_mid_lock", {30'd0, got1, got0}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 31) == 0);
            req0     = ($urandom_range(0, 3) != 0);
            req1     = ($urandom_range(0, 3) != 0);
            lock0    = $urandom_range(0, 1) != 0;
            lock1    = $urandom_range(0, 1) != 0;
            addr0    = $urandom; addr1 = $urandom;
            wdata0   = $urandom; wdata1 = $urandom;
            word_we0 = $urandom_range(0, 1) != 0;
            word_we1 = $urandom_range(0, 1) != 0;
            byte_we0 = $urandom_range(0, 3) == 0;
            byte_we1 = $urandom_range(0, 3) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory (`data_mem`) between the CPU load/store path (port 0) and a DMA/IO requester (port 1). Grants are combinational from registered arbitration state, so a granted access completes in the same cycle, exactly as the single-cycle datapath expects. Round-robin resolves ties, a lock lets a requester hold the memory for back-to-back accesses, and a bounded lock counter prevents starvation. The CPU uses `stall0` to hold its PC register enable low while it waits.

## Interface
- `MAX_LOCK`, 4: maximum consecutive granted cycles a locked owner keeps while the other port is requesting (≥1).
- `clock` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `req0`, `req1` in 1: access request, port 0 / port 1.
- `lock0`, `lock1` in 1: with `req`, request to keep ownership next cycle.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: store data.
- `word_we0`, `word_we1` in 1: word write enable.
- `byte_we0`, `byte_we1` in 1: byte write enable.
- `gnt0`, `gnt1` out 1: access performed this cycle; at most one high.
- `stall0`, `stall1` out 1: `req & ~gnt` per port.
- `rdata` out 32: `mem_rdata` broadcast; meaningful only to the granted port.
- `mem_addr`, `mem_wdata` out 32: to `data_mem`.
- `mem_word_we`, `mem_byte_we` out 1: to `data_mem`.
- `mem_rdata` in 32: from `data_mem` (combinational read).

## Operation
- State: `owner` ∈ {IDLE, OWN0, OWN1}; `last` (1 bit, last granted port); `run_cnt` (consecutive same-port grants, width clog2(MAX_LOCK)+1, saturating at MAX_LOCK).
- Grant selection per cycle, in priority order:
  - `reset`=1 → no grant.
  - `owner`=OWNx, `reqx`=1, and (`run_cnt` < MAX_LOCK or other `req`=0) → grant x.
  - Both requesting → grant port ≠ `last`.
  - Exactly one requesting → grant it.
  - Otherwise no grant.
- Memory mux: granted port drives `mem_addr`/`mem_wdata`/`mem_*_we`. With no grant, `mem_*_we`=0 and `mem_addr`/`mem_wdata` = port 0 values. An ungranted port's enables never reach memory.
- Edge update:
  - Grant to g: `last`←g. `owner`←OWNg if `lockg`, else IDLE. `run_cnt`←min(`run_cnt`+1, MAX_LOCK) if g equals the previous cycle's grant, else 1.
  - No grant: `owner`←IDLE, `run_cnt`←0, `last` unchanged.
- Owner dropping `req` (even with lock still high) releases ownership immediately, and arbitration proceeds normally that cycle.
- Forced handover: locked owner at `run_cnt`=MAX_LOCK with the other port requesting loses to round-robin (`last`=owner, so the other port wins).
- Lock without contention holds indefinitely. `run_cnt` saturates and does not wrap.

## Timing
- Reset values: `owner`=IDLE, `last`=1 (port 0 wins the first tie), `run_cnt`=0. While `reset`=1: `gnt*`=0, `mem_*_we`=0, and `stall*`=`req*`.
- Grant latency is 0 cycles: request, grant and memory access all occur in the same cycle. The write commits at the edge ending that cycle. `rdata` is valid in the grant cycle.
- Requester must hold `req`/`addr`/`wdata`/enables stable until it sees `gnt`. Deasserting `req` before grant is allowed (the request is withdrawn).
- Reset asserted mid-lock aborts ownership. The next post-reset cycle uses fresh state.
- All outputs are combinational from inputs and registered state; there are no registered outputs.

## Test plan
- Reset with `req0`=`req1`=1 → `gnt0`=`gnt1`=0, `mem_word_we`=0, `stall0`=`stall1`=1. First cycle after release → `gnt0`=1.
- `req0`=`req1`=1, no lock, 6 cycles → grants 0,1,0,1,0,1. Each `mem_addr` matches that cycle's granted `addr`.
- MAX_LOCK=4: `req1`+`lock1` from cycle 0, `req0` from cycle 0 (`last`=0) → `gnt1` cycles 0–3, `gnt0` cycle 4, `stall0`=1 cycles 0–3.
- `req0`+`lock0` for 10 cycles, `req1`=0 → `gnt0` all 10. `req1` rises at cycle 10 → `gnt1` at cycle 10 (`run_cnt` saturated at 4).
- Both granted-path and ungranted-path writes in one cycle: port 1 granted with `byte_we1`=1, `addr1`=0x10010003, `wdata1`=0xAB, while port 0 has `word_we0`=1 → `mem_byte_we`=1, `mem_word_we`=0, `mem_addr`=0x10010003, `mem_wdata`=0xAB. A subsequent read of that address returns byte 0xAB in `rdata[31:24]`.
- Reset pulsed during port-1 lock with both requesting → next cycle `gnt0`=1 (`last` restored to 1, ownership cleared).
